axis_frame_sink_checker: RTL and testbench
==========================================

# axis_frame_sink_checker

Synthesizable AXI4-Stream sink that sits directly downstream of the XGS_athena `system_top` video output (64-bit `tx` stream, 4-bit `tuser`) and consumes every beat the DMA/packer produces. It checks frame and line framing against programmed geometry, accumulates a per-frame 32-bit checksum, and reports sticky errors and frame counts. It optionally throttles `tready` pseudo-randomly to exercise upstream backpressure.

## Interface
- `DATA_WIDTH`, 64, stream data width; must be a multiple of 32.
- `USER_WIDTH`, 4, `tuser` width; bits [3:0] are used.
- `CNT_WIDTH`, 16, width of the beat and line counters and geometry inputs.
- `LFSR_SEED`, 16'hACE1, backpressure LFSR reset value; must be nonzero.

- `aclk` in 1 — single clock.
- `aclk_reset_n` in 1 — synchronous, active-low reset.
- `s_axis_tvalid` in 1 — beat valid.
- `s_axis_tready` out 1 — sink ready.
- `s_axis_tdata` in DATA_WIDTH — pixel data.
- `s_axis_tlast` in 1 — end of line; must equal `tuser[3]`.
- `s_axis_tuser` in USER_WIDTH — [0] SOF, [1] EOF, [2] SOL, [3] EOL.
- `cfg_line_beats` in CNT_WIDTH — expected beats per line.
- `cfg_lines` in CNT_WIDTH — expected lines per frame.
- `cfg_bp_level` in 4 — backpressure level, 0 = never throttle.
- `clr_errors` in 1 — clears `err_flags`.
- `frame_done` out 1 — one-cycle pulse per completed frame.
- `frame_count` out 32 — completed frames since reset, wraps.
- `last_checksum` out 32 — checksum of last completed frame.
- `last_line_count` out CNT_WIDTH — lines seen in last completed frame.
- `err_flags` out 4 — sticky: [0] SOF inside frame, [1] beat outside frame, [2] line length or tlast/EOL mismatch, [3] line count mismatch at EOF.

## Operation
- Beat accepted when `s_axis_tvalid & s_axis_tready` on rising `aclk`; all processing is per accepted beat.
- States: `S_IDLE` (no frame), `S_FRAME` (in frame).
- `cfg_line_beats` and `cfg_lines` are latched on the SOF beat; changes mid-frame have no effect until the next SOF.
- `S_IDLE`: SOF beat → latch cfg, beat_cnt=1, line_cnt=0, checksum=lane sum of beat → `S_FRAME`. Non-SOF beat → consumed, discarded, set err[1].
- `S_FRAME`: non-SOF beat → beat_cnt+1, checksum += lane sum. SOF beat → set err[0], restart frame exactly as from `S_IDLE`.
- EOL beat (`tuser[3]`): compare beat_cnt including this beat with latched `cfg_line_beats`; mismatch sets err[2]; line_cnt+1; beat_cnt=0.
- `tlast != tuser[3]` on any beat sets err[2].
- EOF beat (`tuser[1]`): must also be EOL, else err[2]. Compare final line_cnt with latched `cfg_lines`; mismatch sets err[3]. Pulse `frame_done`, update outputs, → `S_IDLE`.
- SOF+EOF in one beat is a legal one-beat frame; all checks above apply to it.
- Lane sum: modulo-2^32 sum of all 32-bit lanes of `tdata`.
- beat_cnt and line_cnt saturate at all-ones; no wrap.
- err_flags: a bit set and `clr_errors` in the same cycle → bit stays set (set wins).

## Timing
- Reset values: `s_axis_tready`=0, `frame_done`=0, `frame_count`=0, `last_checksum`=0, `last_line_count`=0, `err_flags`=0, state `S_IDLE`, LFSR=`LFSR_SEED`.
- Reset mid-frame discards the partial frame; no `frame_done`.
- `frame_done`, `frame_count`, `last_checksum`, `last_line_count` update one cycle after the EOF beat is accepted.
- err bits assert one cycle after the offending beat.
- `s_axis_tready` is registered and independent of `s_axis_tvalid`; asserts the first cycle after reset release (when not throttled).
- Throughput: one beat per cycle; back-to-back frames with no idle cycle.

## Configuration
- `AXIS_SINK_BACKPRESSURE_EN` defined: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances every cycle; registered `s_axis_tready` = (lfsr[3:0] >= `cfg_bp_level`). Level 0 → always ready.
- Not defined: no LFSR; `cfg_bp_level` ignored; `s_axis_tready`=1 every cycle after reset release.

## Test plan
- Frame 4 lines × 8 beats, tdata = {32'h1, 32'h2} each beat, cfg 8/4 → one `frame_done`, `frame_count`=1, `last_checksum`=0x60, `last_line_count`=4, `err_flags`=0.
- Line 2 with 7 beats, cfg 8/4 → err[2]=1, frame still completes, `frame_done` pulses; `clr_errors` → 0.
- EOF after 3 lines, cfg 8/4 → err[3]=1, `last_line_count`=3.
- SOF mid-frame after 10 beats, then clean 4×8 frame → err[0]=1, exactly one `frame_done`, checksum of the restarted frame only; beats sent before any SOF → err[1]=1.
- One-beat frame (SOF|EOF|SOL|EOL, tlast=1), cfg 1/1, tdata=64'hFFFF_FFFF_0000_0001 → `last_checksum`=0, no errors.
- With macro, `cfg_bp_level`=8, 4×8 frame, tvalid held high → tready low on some cycles, no beat lost, checksum identical to unthrottled run; reset asserted mid-frame → all outputs at reset values, no `frame_done`.

Source files
------------

// File: rtl/axis_frame_sink_checker.sv
// axis_frame_sink_checker: AXI4-Stream video sink that checks framing, sums a per-frame checksum and counts frames
// Ports: aclk, aclk_reset_n (synchronous, active-low)
//   s_axis_tvalid/tready/tdata/tlast/tuser - stream input, tuser [0]SOF [1]EOF [2]SOL [3]EOL
//   cfg_line_beats, cfg_lines - expected geometry, latched on each SOF beat
//   cfg_bp_level - tready throttle level (0 = never throttle)
//   clr_errors - clears err_flags (a bit being set in the same cycle wins)
//   frame_done, frame_count, last_checksum, last_line_count - per-frame results
//   err_flags - sticky: [0] SOF in frame, [1] beat outside frame, [2] line length or tlast/EOL, [3] line count
// Optional macro AXIS_SINK_BACKPRESSURE_EN: LFSR-driven pseudo-random tready throttling.
module axis_frame_sink_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 4,
  parameter int CNT_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  aclk,
  input  logic                  aclk_reset_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic [CNT_WIDTH-1:0]  cfg_line_beats,
  input  logic [CNT_WIDTH-1:0]  cfg_lines,
  input  logic [3:0]            cfg_bp_level,
  input  logic                  clr_errors,
  output logic                  frame_done,
  output logic [31:0]           frame_count,
  output logic [31:0]           last_checksum,
  output logic [CNT_WIDTH-1:0]  last_line_count,
  output logic [3:0]            err_flags
);
  typedef enum logic {S_IDLE, S_FRAME} state_t;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] beat_cnt, line_cnt, lat_line_beats, lat_lines;
  logic [CNT_WIDTH-1:0] beat_cnt_n, line_cnt_n, lat_line_beats_n, lat_lines_n;
  logic [CNT_WIDTH-1:0] base_beats, base_lines, beats, lines, exp_beats, exp_lines;
  logic [31:0] checksum, checksum_n, lane_sum, sum;
  logic [3:0] err_set;
  logic acc, sof, eof, eol, in_frame, done_n;
  logic unused_user;
  assign acc = s_axis_tvalid & s_axis_tready;
  assign sof = s_axis_tuser[0];
  assign eof = s_axis_tuser[1];
  assign eol = s_axis_tuser[3];
  assign unused_user = ^s_axis_tuser;
  assign in_frame = sof | (state == S_FRAME);
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < DATA_WIDTH / 32; i++) lane_sum = lane_sum + s_axis_tdata[i*32 +: 32];
  end
  // A SOF beat starts from zeroed counters and the live geometry, so a restart behaves like a fresh frame
  always_comb begin
    base_beats = sof ? '0 : beat_cnt;
    base_lines = sof ? '0 : line_cnt;
    beats = &base_beats ? base_beats : base_beats + CNT_WIDTH'(1);
    lines = (eol && !(&base_lines)) ? base_lines + CNT_WIDTH'(1) : base_lines;
    exp_beats = sof ? cfg_line_beats : lat_line_beats;
    exp_lines = sof ? cfg_lines : lat_lines;
    sum = (sof ? 32'd0 : checksum) + lane_sum;
    state_n = state;
    beat_cnt_n = beat_cnt;
    line_cnt_n = line_cnt;
    checksum_n = checksum;
    lat_line_beats_n = lat_line_beats;
    lat_lines_n = lat_lines;
    err_set = '0;
    done_n = 1'b0;
    if (acc) begin
      err_set[0] = sof && state == S_FRAME;
      err_set[1] = !in_frame;
      err_set[2] = (s_axis_tlast != eol) || (in_frame && ((eol && beats != exp_beats) || (eof && !eol)));
      err_set[3] = in_frame && eof && lines != exp_lines;
      if (in_frame) begin
        done_n = eof;
        state_n = eof ? S_IDLE : S_FRAME;
        beat_cnt_n = eol ? '0 : beats;
        line_cnt_n = lines;
        checksum_n = sum;
        lat_line_beats_n = exp_beats;
        lat_lines_n = exp_lines;
      end
    end
  end
  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      state <= S_IDLE;
      beat_cnt <= '0;
      line_cnt <= '0;
      checksum <= '0;
      lat_line_beats <= '0;
      lat_lines <= '0;
      frame_done <= 1'b0;
      frame_count <= '0;
      last_checksum <= '0;
      last_line_count <= '0;
      err_flags <= '0;
    end else begin
      state <= state_n;
      beat_cnt <= beat_cnt_n;
      line_cnt <= line_cnt_n;
      checksum <= checksum_n;
      lat_line_beats <= lat_line_beats_n;
      lat_lines <= lat_lines_n;
      frame_done <= done_n;
      if (done_n) begin
        frame_count <= frame_count + 32'd1;
        last_checksum <= checksum_n;
        last_line_count <= line_cnt_n;
      end
      err_flags <= (err_flags & {4{~clr_errors}}) | err_set;
    end
  end
`ifdef AXIS_SINK_BACKPRESSURE_EN
  logic [15:0] lfsr;
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1
  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      lfsr <= LFSR_SEED;
      s_axis_tready <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      s_axis_tready <= lfsr[3:0] >= cfg_bp_level;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{cfg_bp_level, LFSR_SEED};
  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) s_axis_tready <= 1'b0;
    else s_axis_tready <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_axis_frame_sink_checker.sv
// tb_axis_frame_sink_checker: directed self-checking bench for axis_frame_sink_checker
module tb_axis_frame_sink_checker;
  logic aclk = 1'b0;
  logic aclk_reset_n = 1'b0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tlast = 1'b0;
  logic clr_errors = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [3:0] s_axis_tuser = '0;
  logic [15:0] cfg_line_beats = 16'd8;
  logic [15:0] cfg_lines = 16'd4;
  logic [3:0] cfg_bp_level = '0;
  logic s_axis_tready, frame_done;
  logic [31:0] frame_count, last_checksum;
  logic [15:0] last_line_count;
  logic [3:0] err_flags;
  int checks = 0, errors = 0, dones = 0, stalls = 0;
  localparam logic [63:0] D12 = {32'h1, 32'h2};
  localparam logic [63:0] D34 = {32'h10, 32'h20};
  axis_frame_sink_checker dut (
    .aclk(aclk), .aclk_reset_n(aclk_reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .cfg_line_beats(cfg_line_beats), .cfg_lines(cfg_lines), .cfg_bp_level(cfg_bp_level),
    .clr_errors(clr_errors), .frame_done(frame_done), .frame_count(frame_count),
    .last_checksum(last_checksum), .last_line_count(last_line_count), .err_flags(err_flags)
  );
  always #5 aclk = ~aclk;
  always @(negedge aclk) if (frame_done) dones++;
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic [63:0] d, input logic [3:0] u, input logic l);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_tuser = u;
    s_axis_tlast = l;
    while (!s_axis_tready && n < 64) begin
      @(negedge aclk);
      n++;
    end
    stalls += n;
    if (!s_axis_tready) chk("tready_timeout", 32'd0, 32'd1);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask
  task automatic line(input int nb, input logic [63:0] d, input logic first, input logic fin);
    for (int j = 0; j < nb; j++)
      beat(d, {j == nb - 1, j == 0, fin && j == nb - 1, first && j == 0}, j == nb - 1);
  endtask
  task automatic frame(input int nl, input int nb, input logic [63:0] d, input int short_ln);
    for (int k = 0; k < nl; k++) line(k == short_ln ? nb - 1 : nb, d, k == 0, k == nl - 1);
  endtask
  task automatic clear;
    clr_errors = 1'b1;
    @(negedge aclk);
    clr_errors = 1'b0;
    chk("err_cleared", {28'd0, err_flags}, 32'h0);
  endtask
  initial begin
    repeat (3) @(negedge aclk);
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_count", frame_count, 32'd0);
    chk("rst_csum", last_checksum, 32'd0);
    chk("rst_lines", {16'd0, last_line_count}, 32'd0);
    chk("rst_err", {28'd0, err_flags}, 32'd0);
    aclk_reset_n = 1'b1;
    @(negedge aclk);
    chk("tready_release", {31'd0, s_axis_tready}, 32'd1);
    frame(4, 8, D12, -1);
    @(negedge aclk);
    chk("clean_count", frame_count, 32'd1);
    chk("clean_csum", last_checksum, 32'h60);
    chk("clean_lines", {16'd0, last_line_count}, 32'd4);
    chk("clean_err", {28'd0, err_flags}, 32'h0);
    chk("clean_dones", dones, 32'd1);
    frame(4, 8, D12, 1);
    @(negedge aclk);
    chk("short_err", {28'd0, err_flags}, 32'h4);
    chk("short_count", frame_count, 32'd2);
    chk("short_csum", last_checksum, 32'h5D);
    chk("short_dones", dones, 32'd2);
    clear();
    frame(3, 8, D12, -1);
    @(negedge aclk);
    chk("lines_err", {28'd0, err_flags}, 32'h8);
    chk("lines_last", {16'd0, last_line_count}, 32'd3);
    chk("lines_csum", last_checksum, 32'h48);
    chk("lines_dones", dones, 32'd3);
    clear();
    line(8, D12, 1'b1, 1'b0);
    beat(D12, 4'h4, 1'b0);
    beat(D12, 4'h0, 1'b0);
    frame(4, 8, D34, -1);
    @(negedge aclk);
    chk("restart_err", {28'd0, err_flags}, 32'h1);
    chk("restart_dones", dones, 32'd4);
    chk("restart_count", frame_count, 32'd4);
    chk("restart_csum", last_checksum, 32'h600);
    clear();
    beat(64'h5, 4'h0, 1'b0);
    beat(64'h7, 4'h4, 1'b0);
    @(negedge aclk);
    chk("outside_err", {28'd0, err_flags}, 32'h2);
    chk("outside_count", frame_count, 32'd4);
    clear();
    cfg_line_beats = 16'd1;
    cfg_lines = 16'd1;
    beat(64'hFFFF_FFFF_0000_0001, 4'hF, 1'b1);
    @(negedge aclk);
    chk("one_csum", last_checksum, 32'h0);
    chk("one_err", {28'd0, err_flags}, 32'h0);
    chk("one_lines", {16'd0, last_line_count}, 32'd1);
    chk("one_count", frame_count, 32'd5);
    beat(64'h5, 4'hF, 1'b0);
    @(negedge aclk);
    chk("tlast_err", {28'd0, err_flags}, 32'h4);
    chk("tlast_csum", last_checksum, 32'h5);
    chk("tlast_count", frame_count, 32'd6);
    clear();
    cfg_line_beats = 16'd8;
    cfg_lines = 16'd4;
    cfg_bp_level = 4'd8;
    stalls = 0;
    frame(4, 8, D12, -1);
    @(negedge aclk);
    chk("bp_csum", last_checksum, 32'h60);
    chk("bp_count", frame_count, 32'd7);
    chk("bp_err", {28'd0, err_flags}, 32'h0);
    chk("bp_dones", dones, 32'd7);
`ifdef AXIS_SINK_BACKPRESSURE_EN
    chk("bp_stalled", {31'd0, stalls != 0}, 32'd1);
`endif
    cfg_bp_level = 4'd0;
    line(8, D12, 1'b1, 1'b0);
    beat(D12, 4'h4, 1'b0);
    aclk_reset_n = 1'b0;
    repeat (2) @(negedge aclk);
    chk("mrst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("mrst_count", frame_count, 32'd0);
    chk("mrst_csum", last_checksum, 32'd0);
    chk("mrst_lines", {16'd0, last_line_count}, 32'd0);
    chk("mrst_err", {28'd0, err_flags}, 32'd0);
    chk("mrst_dones", dones, 32'd7);
    aclk_reset_n = 1'b1;
    @(negedge aclk);
    frame(4, 8, D12, -1);
    @(negedge aclk);
    chk("post_count", frame_count, 32'd1);
    chk("post_csum", last_checksum, 32'h60);
    chk("post_err", {28'd0, err_flags}, 32'h0);
    chk("post_dones", dones, 32'd8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
